// File: rtl/cache_arbiter.sv
// cache_arbiter: arbitrates one single-ported RAM between an icache (fetch)
// and a dcache (load/store) requester. The dcache has priority, except that
// the icache is granted after STARVE_LIMIT consecutive dcache grants while
// it was waiting.
//
// Ports:
//   CLK, nRST              clock (rising edge), async active-low reset
//   iREN, iaddr            icache fetch request and word address
//   iwait, iload           icache wait (low in completion cycle) and data
//   dREN, dWEN             dcache load / store request (both high = store)
//   daddr, dstore          dcache address and store data
//   dwait, dload           dcache wait (low in completion cycle) and data
//   ramREN, ramWEN         RAM read / write strobes (registered)
//   ramaddr, ramstore      RAM address / store data, latched at grant
//   ramload, ramstate      RAM read data and status (FREE/BUSY/ACCESS/ERROR)
module cache_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int unsigned CNT_W = 3;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IFETCH, DLOAD, DSTORE} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             at_limit;
  logic             starved;
  logic             ram_done;
  logic [CNT_W-1:0] cnt_next_d;

  assign at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign starved  = iREN && at_limit;
  // ACCESS completes the transfer; ERROR ends it without completion (retry).
  assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);

  // Counter value for a dcache grant: count only while the icache is waiting.
  assign cnt_next_d = !iREN ? '0 : (at_limit ? starve_cnt : starve_cnt + CNT_W'(1));

  // Arbitration FSM with registered RAM controls.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= '0;
      ramstore   <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (starved) begin
            state      <= IFETCH;
            ramREN     <= 1'b1;
            ramaddr    <= iaddr;
            starve_cnt <= '0;
          end else if (dWEN) begin
            state      <= DSTORE;
            ramWEN     <= 1'b1;
            ramaddr    <= daddr;
            ramstore   <= dstore;
            starve_cnt <= cnt_next_d;
          end else if (dREN) begin
            state      <= DLOAD;
            ramREN     <= 1'b1;
            ramaddr    <= daddr;
            starve_cnt <= cnt_next_d;
          end else if (iREN) begin
            state      <= IFETCH;
            ramREN     <= 1'b1;
            ramaddr    <= iaddr;
            starve_cnt <= '0;
          end
        end
        default: begin
          if (ram_done) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
      endcase
    end
  end

  // Waits drop combinationally in the ACCESS cycle for the owner only.
  assign iwait = !((state == IFETCH) && (ramstate == RAM_ACCESS));
  assign dwait = !(((state == DLOAD) || (state == DSTORE)) && (ramstate == RAM_ACCESS));

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter (STARVE_LIMIT = 4).
module tb_cache_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_chk  = 0;
  int n_pass = 0;

  cache_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present ACCESS for one cycle, check waits, then return RAM to FREE.
  task automatic complete(input string tag, input logic exp_iw, input logic exp_dw);
    ramstate = ACCESS;
    #1;
    check({tag, "_iwait"}, 32'(iwait), 32'(exp_iw));
    check({tag, "_dwait"}, 32'(dwait), 32'(exp_dw));
    step();
    ramstate = FREE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = 32'h2008_0001; ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ramREN",   32'(ramREN), 32'd0);
    check("rst_ramWEN",   32'(ramWEN), 32'd0);
    check("rst_ramaddr",  ramaddr,     32'd0);
    check("rst_ramstore", ramstore,    32'd0);
    check("rst_iwait",    32'(iwait),  32'd1);
    check("rst_dwait",    32'(dwait),  32'd1);
    @(negedge CLK);
    nRST = 1'b1;

    // Single fetch with ACCESS two cycles after ramREN.
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h0000_0040;
    step();
    iREN = 1'b0;
    check("f_ramREN",  32'(ramREN), 32'd1);
    check("f_ramWEN",  32'(ramWEN), 32'd0);
    check("f_ramaddr", ramaddr,     32'h40);
    ramstate = BUSY;
    #1;
    check("f_busy_iwait", 32'(iwait), 32'd1);
    step();
    ramstate = ACCESS;
    #1;
    check("f_iwait", 32'(iwait), 32'd0);
    check("f_iload", iload,      32'h2008_0001);
    check("f_dwait", 32'(dwait), 32'd1);
    step();
    ramstate = FREE;
    #1;
    check("f_idle_ramREN", 32'(ramREN), 32'd0);
    check("f_idle_iwait",  32'(iwait),  32'd1);

    // Collision: dcache first, one idle cycle, then icache.
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
    step();
    dREN = 1'b0;
    check("c_d_ramaddr", ramaddr,     32'h100);
    check("c_d_ramREN",  32'(ramREN), 32'd1);
    complete("c_d", 1'b1, 1'b0);
    check("c_gap_ramREN", 32'(ramREN), 32'd0);
    step();
    iREN = 1'b0;
    check("c_i_ramaddr", ramaddr,     32'h80);
    check("c_i_ramREN",  32'(ramREN), 32'd1);
    complete("c_i", 1'b0, 1'b1);

    // Store priority and latched address/data stability.
    step();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    step();
    dREN = 1'b0; dWEN = 1'b0; daddr = 32'h999; dstore = 32'h1234_5678;
    check("s_ramWEN",   32'(ramWEN), 32'd1);
    check("s_ramREN",   32'(ramREN), 32'd0);
    check("s_ramaddr",  ramaddr,     32'h200);
    check("s_ramstore", ramstore,    32'hDEAD_BEEF);
    ramstate = BUSY;
    step();
    check("s_hold_ramaddr",  ramaddr,    32'h200);
    check("s_hold_ramstore", ramstore,   32'hDEAD_BEEF);
    check("s_hold_dwait",    32'(dwait), 32'd1);
    complete("s", 1'b1, 1'b0);

    // Starvation: four dcache grants, then one icache grant, then dcache again.
    step();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h300;
    for (int g = 0; g < 6; g++) begin
      logic [31:0] exp_addr;
      exp_addr = (g == 4) ? 32'h44 : 32'h300;
      step();
      check($sformatf("starve_grant%0d", g), ramaddr, exp_addr);
      complete($sformatf("starve%0d", g), (g == 4) ? 1'b0 : 1'b1, (g == 4) ? 1'b1 : 1'b0);
    end
    iREN = 1'b0; dREN = 1'b0;
    step();

    // ERROR during DLOAD: no completion, then retry at the same address.
    dREN = 1'b1; daddr = 32'h400;
    step();
    check("e_ramaddr", ramaddr, 32'h400);
    ramstate = ERROR;
    #1;
    check("e_dwait", 32'(dwait), 32'd1);
    step();
    ramstate = FREE;
    check("e_idle_ramREN", 32'(ramREN), 32'd0);
    step();
    dREN = 1'b0;
    check("e_retry_ramREN",  32'(ramREN), 32'd1);
    check("e_retry_ramaddr", ramaddr,     32'h400);
    complete("e_retry", 1'b1, 1'b0);

    // Reset asserted during IFETCH abandons the access.
    step();
    iREN = 1'b1; iaddr = 32'h500;
    step();
    iREN = 1'b0;
    check("r_ramREN", 32'(ramREN), 32'd1);
    ramstate = BUSY;
    #2;
    nRST = 1'b0;
    #1;
    check("r_now_ramREN",  32'(ramREN), 32'd0);
    check("r_now_ramaddr", ramaddr,     32'd0);
    check("r_now_iwait",   32'(iwait),  32'd1);
    ramstate = ACCESS;
    #1;
    check("r_acc_iwait", 32'(iwait), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("r_post_iwait%0d", k), 32'(iwait), 32'd1);
    end
    ramstate = FREE;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4 (range 1-7): max consecutive dcache grants while iREN is pending.
REQ-002 SHALL have ports: CLK  in  1  clock, rising edge; all state changes occur on this edge.
REQ-003 SHALL have ports: nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: iREN  in  1  icache fetch request; iaddr  in  32  fetch word address.
REQ-005 SHALL have ports: iwait  out  1  low only in completion cycle of icache access; iload  out  32  fetch data.
REQ-006 SHALL have ports: dREN  in  1  dcache load request; dWEN  in  1  dcache store request; daddr  in  32; dstore  in  32  store data.
REQ-007 SHALL have ports: dwait  out  1  low only in completion cycle of dcache access; dload  out  32  load data.
REQ-008 SHALL have ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32; ramload  in  32; ramstate  in  2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3).

Function
REQ-009 SHALL implement registered FSM with states IDLE, IFETCH, DLOAD, DSTORE.
REQ-010 IDLE: ramREN=ramWEN=0, iwait=dwait=1.
REQ-011 IDLE exit at next edge: dWEN=1 -> DSTORE; else dREN=1 -> DLOAD; else iREN=1 -> IFETCH; else stay IDLE.
REQ-012 Exception to REQ-011: if iREN=1 and starvation counter == STARVE_LIMIT, SHALL go to IFETCH regardless of dREN/dWEN.
REQ-013 dREN and dWEN both high SHALL be treated as a store (DSTORE).
REQ-014 On the IDLE->busy edge SHALL latch selected address into ramaddr and, for DSTORE, dstore into ramstore; both stay stable until return to IDLE.
REQ-015 IFETCH/DLOAD: ramREN=1, ramWEN=0; DSTORE: ramWEN=1, ramREN=0.
REQ-016 In busy state with ramstate=ACCESS: the owning requester's wait SHALL be 0 that cycle (combinational); FSM -> IDLE next edge.
REQ-017 ramstate FREE or BUSY in busy state: hold state, waits stay 1.
REQ-018 ramstate ERROR in busy state: waits stay 1, FSM -> IDLE next edge; requester still asserting is re-arbitrated (retry).
REQ-019 iload and dload SHALL continuously follow ramload; valid only when respective wait=0.
REQ-020 Non-owning requester's wait SHALL be 1 at all times.
REQ-021 Minimum access latency: request seen in IDLE at edge N -> wait low earliest in cycle after edge N+1 (one-cycle turnaround IDLE between back-to-back accesses).
REQ-022 Requester dropping its request mid-access: access SHALL still complete at RAM; no abort; wait behaviour unchanged.
REQ-023 Starvation counter (3 bits, saturating at STARVE_LIMIT): on each IDLE->DLOAD/DSTORE transition with iREN=1, increment; on IDLE->IFETCH or IDLE->D* with iREN=0, clear to 0.
REQ-024 Changes to iaddr/daddr/dstore during a busy state SHALL NOT affect ramaddr/ramstore.

Reset
REQ-025 nRST low SHALL immediately force: state=IDLE, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, counter=0, iwait=1, dwait=1.
REQ-026 Reset asserted mid-access SHALL abandon the access; no wait deasserts for it after reset release.
REQ-027 First arbitration SHALL occur at the first rising edge after nRST deasserts.

Verification
REQ-028 Single fetch: iREN=1, iaddr=0x0000_0040, RAM gives ACCESS 2 cycles after ramREN -> ramREN=1, ramaddr=0x40, iwait=0 for exactly one cycle, iload=ramload=0x2008_0001.
REQ-029 Collision: iREN=dREN=1 same cycle, daddr=0x100 -> DLOAD first (ramaddr=0x100), dwait low once, IDLE one cycle, then IFETCH, iwait low once.
REQ-030 Store priority: dREN=dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dwait low on ACCESS.
REQ-031 Starvation: iREN held, dREN held continuously, STARVE_LIMIT=4 -> exactly 4 dcache grants then one IFETCH, counter back to 0, then dcache resumes.
REQ-032 Error/reset: ramstate=ERROR during DLOAD -> dwait stays 1, re-grant DLOAD same address; separately, nRST low during IFETCH -> outputs at reset values immediately, iwait never pulses low.
